// File: rtl/cosim_constants_pkg.sv
// Shared widths, word counts and enums for the co-simulation log item assembler.
package cosim_constants_pkg;

    localparam int C_DPI_W  = 32;
    localparam int C_XREG_W = 64;
    localparam int C_FREG_W = 128;

    typedef enum logic {
        KIND_REG = 1'b0,
        KIND_MEM = 1'b1
    } item_kind_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } asm_state_e;

    function automatic int calc_reg_words(input int dpi_w, input int xreg_w, input int freg_w);
        return (xreg_w / dpi_w) + (freg_w / dpi_w);
    endfunction

    // Memory item: address, data and one control word.
    function automatic int calc_mem_words(input int dpi_w, input int xreg_w);
        return ((2 * xreg_w) / dpi_w) + 1;
    endfunction

    function automatic int calc_item_w(input int dpi_w, input int xreg_w, input int freg_w);
        int rw;
        int mw;
        rw = calc_reg_words(dpi_w, xreg_w, freg_w);
        mw = calc_mem_words(dpi_w, xreg_w);
        return ((rw > mw) ? rw : mw) * dpi_w;
    endfunction

    localparam int C_REG_WORDS = calc_reg_words(C_DPI_W, C_XREG_W, C_FREG_W);
    localparam int C_MEM_WORDS = calc_mem_words(C_DPI_W, C_XREG_W);
    localparam int C_ITEM_W    = calc_item_w(C_DPI_W, C_XREG_W, C_FREG_W);

endpackage

// File: rtl/cosim_sync_fifo.sv
// Single-clock FIFO with registered storage; head is presented from storage at the read pointer.
module cosim_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == CNT_W'(DEPTH));
    assign empty_o   = (r_count == CNT_W'(0));
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;
    assign head_o    = r_mem[r_rd_ptr];
    assign count_o   = r_count;

    // Storage and write pointer; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer advances on every effective pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
        end else if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end else begin
            r_rd_ptr <= r_rd_ptr;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cosim_log_item_assembler.sv
// Collects DPI words into register-write or memory-access log items and queues them in a FIFO.
// Optional macro COSIM_ASM_KIND_CHECK_EN enables the sticky kind-mismatch error and restart.
module cosim_log_item_assembler
    import cosim_constants_pkg::*;
#(
    parameter  int DPI_W     = C_DPI_W,
    parameter  int XREG_W    = C_XREG_W,
    parameter  int FREG_W    = C_FREG_W,
    parameter  int DEPTH     = 4,
    localparam int REG_WORDS = calc_reg_words(DPI_W, XREG_W, FREG_W),
    localparam int MEM_WORDS = calc_mem_words(DPI_W, XREG_W),
    localparam int ITEM_W    = calc_item_w(DPI_W, XREG_W, FREG_W),
    localparam int MAX_WORDS = ITEM_W / DPI_W,
    localparam int SLOT_W    = $clog2(MAX_WORDS + 1),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_kind_i,
    input  logic [DPI_W-1:0]  in_word_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_kind_o,
    output logic [ITEM_W-1:0] out_item_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              err_o
);

    asm_state_e        r_state;
    item_kind_e        r_kind;
    logic [SLOT_W-1:0] r_cnt;
    logic [ITEM_W-1:0] r_item;

    logic              w_restart;
    item_kind_e        w_kind;
    logic [SLOT_W-1:0] w_slot;
    logic [SLOT_W-1:0] w_last_idx;
    logic              w_is_last;
    logic              w_accept;
    logic              w_push;
    logic [ITEM_W-1:0] w_item_next;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ITEM_W:0]   w_head;
`ifdef COSIM_ASM_KIND_CHECK_EN
    logic              w_kind_err;
    logic              r_err;
`endif

    // Decide where the offered word lands: slot 0 of a fresh item, or the next slot of the held one.
    always_comb begin
        w_restart = 1'b1;
        w_kind    = item_kind_e'(in_kind_i);
        w_slot    = '0;
`ifdef COSIM_ASM_KIND_CHECK_EN
        w_kind_err = 1'b0;
`endif
        if (r_state == S_COLLECT) begin
`ifdef COSIM_ASM_KIND_CHECK_EN
            if (item_kind_e'(in_kind_i) != r_kind) begin
                w_kind_err = 1'b1;
            end else begin
                w_restart = 1'b0;
                w_kind    = r_kind;
                w_slot    = r_cnt;
            end
`else
            w_restart = 1'b0;
            w_kind    = r_kind;
            w_slot    = r_cnt;
`endif
        end else begin
            w_restart = 1'b1;
        end
    end

    // Completion detection and item image including the offered word.
    always_comb begin
        w_last_idx = (w_kind == KIND_MEM) ? SLOT_W'(MEM_WORDS - 1) : SLOT_W'(REG_WORDS - 1);
        w_is_last  = (w_slot == w_last_idx);
        w_item_next = w_restart ? '0 : r_item;
        w_item_next[int'(w_slot) * DPI_W +: DPI_W] = in_word_i;
    end

    // Only the completing word can be refused, and only because the FIFO is already full.
    assign in_ready_o = ~(w_is_last & w_fifo_full);
    assign w_accept   = in_valid_i & in_ready_o;
    assign w_push     = w_accept & w_is_last;

    // Assembly FSM: a completed item goes straight into the FIFO and the buffer is cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_kind  <= KIND_REG;
            r_cnt   <= '0;
            r_item  <= '0;
        end else if (w_accept) begin
            if (w_push) begin
                r_state <= S_IDLE;
                r_kind  <= w_kind;
                r_cnt   <= '0;
                r_item  <= '0;
            end else begin
                r_state <= S_COLLECT;
                r_kind  <= w_kind;
                r_cnt   <= w_slot + SLOT_W'(1);
                r_item  <= w_item_next;
            end
        end else begin
            r_state <= r_state;
            r_kind  <= r_kind;
            r_cnt   <= r_cnt;
            r_item  <= r_item;
        end
    end

`ifdef COSIM_ASM_KIND_CHECK_EN
    // Sticky error on an accepted word whose kind disagrees with the held partial item.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept && w_kind_err) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    cosim_sync_fifo #(
        .WIDTH (ITEM_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i ({w_kind, w_item_next}),
        .pop_i       (out_ready_i & out_valid_o),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (out_count_o)
    );

    assign out_valid_o = ~w_fifo_empty;
    assign out_kind_o  = w_head[ITEM_W];
    assign out_item_o  = w_head[ITEM_W-1:0];

endmodule

// File: tb/tb_cosim_log_item_assembler.sv
// Self-checking bench: vector table plus directed backpressure, reset and kind-change sequences.
module tb_cosim_log_item_assembler;

    localparam int IW = 192;

    typedef struct packed {
        logic          kind;
        logic [IW-1:0] item;
    } exp_t;

    typedef struct {
        logic          kind;
        logic [31:0]   w [6];
        logic [IW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          in_kind_i;
    logic [31:0]   in_word_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          out_kind_o;
    logic [IW-1:0] out_item_o;
    logic [2:0]    out_count_o;
    logic          err_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    cosim_log_item_assembler dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_kind_i   (in_kind_i),
        .in_word_i   (in_word_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_kind_o  (out_kind_o),
        .out_item_o  (out_item_o),
        .out_count_o (out_count_o),
        .err_o       (err_o)
    );

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Scoreboard: compare every head that will be popped at the coming rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_item: got %h want none", out_item_o);
                end else begin
                    e = sb_q.pop_front();
                    check("out_kind", IW'(out_kind_o), IW'(e.kind));
                    check("out_item", out_item_o, e.item);
                end
            end
        end
    end

    task automatic put_word(input logic k, input logic [31:0] w);
        int budget;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_kind_i  = k;
        in_word_i  = w;
        #1;
        budget = 40;
        while (!in_ready_o && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $display("FAIL put_word_timeout: got ready=0 want ready=1");
        end
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic send_rand_item(input logic k);
        logic [31:0]   ws [6];
        logic [IW-1:0] ex;
        int            n;
        n  = k ? 5 : 6;
        ex = '0;
        for (int i = 0; i < n; i++) begin
            ws[i] = $urandom;
            ex[i*32 +: 32] = ws[i];
        end
        sb_q.push_back({k, ex});
        for (int i = 0; i < n; i++) begin
            put_word(k, ws[i]);
        end
    endtask

    task automatic drain();
        int budget;
        @(negedge clk);
        out_ready_i = 1'b1;
        budget = 60;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        #1;
        check("drain_queue_empty", IW'(sb_q.size()), IW'(0));
        check("drain_count", IW'(out_count_o), IW'(0));
    endtask

    initial begin
        logic [IW-1:0] ex;
        int            n;

        vecs[0].kind = 1'b0;
        vecs[0].w    = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        vecs[0].exp  = 192'h00000006_00000005_00000004_00000003_00000002_00000001;
        vecs[1].kind = 1'b1;
        vecs[1].w    = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
        vecs[1].exp  = 192'h00000000_000000A4_000000A3_000000A2_000000A1_000000A0;
        vecs[2].kind = 1'b0;
        vecs[2].w    = '{32'hFFFFFFFF, 32'h0, 32'hDEADBEEF, 32'h12345678, 32'h80000001, 32'h7FFFFFFE};
        vecs[2].exp  = 192'h7FFFFFFE_80000001_12345678_DEADBEEF_00000000_FFFFFFFF;
        vecs[3].kind = 1'b1;
        vecs[3].w    = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'hCAFEF00D};
        vecs[3].exp  = 192'h00000000_55555555_44444444_33333333_22222222_11111111;

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_kind_i   = 1'b0;
        in_word_i   = 32'h0;
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_in_ready", IW'(in_ready_o), IW'(1));
        check("rst_out_valid", IW'(out_valid_o), IW'(0));
        check("rst_count", IW'(out_count_o), IW'(0));
        check("rst_err", IW'(err_o), IW'(0));

        // Vector table: one item each, with one-cycle output latency checked.
        for (int v = 0; v < 4; v++) begin
            n = vecs[v].kind ? 5 : 6;
            sb_q.push_back({vecs[v].kind, vecs[v].exp});
            for (int i = 0; i < n; i++) begin
                put_word(vecs[v].kind, vecs[v].w[i]);
                #1;
                if (i == n - 2) check("valid_before_last", IW'(out_valid_o), IW'(0));
                if (i == n - 1) check("valid_after_last", IW'(out_valid_o), IW'(1));
            end
        end
        idle_in();
        drain();

        // Backpressure: fill the FIFO, then the 5th item stalls only on its final word.
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_rand_item(1'b0);
        idle_in();
        #1;
        check("full_count", IW'(out_count_o), IW'(4));
        check("full_ready_word0", IW'(in_ready_o), IW'(1));
        ex = '0;
        for (int i = 0; i < 6; i++) ex[i*32 +: 32] = 32'hB0 + 32'(i);
        sb_q.push_back({1'b0, ex});
        for (int i = 0; i < 5; i++) begin
            put_word(1'b0, 32'hB0 + 32'(i));
            #1;
            if (i == 3) check("full_ready_mid", IW'(in_ready_o), IW'(1));
        end
        check("full_ready_last", IW'(in_ready_o), IW'(0));
        @(negedge clk);
        in_valid_i = 1'b1;
        in_word_i  = 32'hB5;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("stall_ready", IW'(in_ready_o), IW'(0));
            check("stall_count", IW'(out_count_o), IW'(4));
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        #1;
        check("ready_no_comb_path", IW'(in_ready_o), IW'(0));
        @(negedge clk);
        out_ready_i = 1'b0;
        #1;
        check("pop_ready_high", IW'(in_ready_o), IW'(1));
        check("pop_count", IW'(out_count_o), IW'(3));
        @(negedge clk);
        in_valid_i = 1'b0;
        #1;
        check("fifth_pushed_count", IW'(out_count_o), IW'(4));
        drain();

        // Push-completing word and pop on the same edge at count 3.
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_rand_item(1'b1);
        idle_in();
        #1;
        check("three_count", IW'(out_count_o), IW'(3));
        ex = '0;
        for (int i = 0; i < 5; i++) ex[i*32 +: 32] = 32'hC0 + 32'(i);
        sb_q.push_back({1'b1, ex});
        for (int i = 0; i < 4; i++) put_word(1'b1, 32'hC0 + 32'(i));
        @(negedge clk);
        in_valid_i  = 1'b1;
        in_kind_i   = 1'b1;
        in_word_i   = 32'hC4;
        out_ready_i = 1'b1;
        @(negedge clk);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check("push_pop_count", IW'(out_count_o), IW'(3));
        drain();

        // Kind change in the middle of an item.
        out_ready_i = 1'b1;
        put_word(1'b0, 32'hD0);
        put_word(1'b0, 32'hD1);
`ifdef COSIM_ASM_KIND_CHECK_EN
        #1;
        check("err_before_mismatch", IW'(err_o), IW'(0));
        ex = '0;
        for (int i = 0; i < 5; i++) ex[i*32 +: 32] = 32'hE0 + 32'(i);
        sb_q.push_back({1'b1, ex});
        put_word(1'b1, 32'hE0);
        #1;
        check("err_after_mismatch", IW'(err_o), IW'(1));
        for (int i = 1; i < 5; i++) put_word(1'b1, 32'hE0 + 32'(i));
        idle_in();
        #1;
        check("err_sticky", IW'(err_o), IW'(1));
`else
        ex = '0;
        ex[31:0]  = 32'hD0;
        ex[63:32] = 32'hD1;
        for (int i = 0; i < 4; i++) ex[(i+2)*32 +: 32] = 32'hE0 + 32'(i);
        sb_q.push_back({1'b0, ex});
        for (int i = 0; i < 4; i++) put_word(1'b1, 32'hE0 + 32'(i));
        idle_in();
        #1;
        check("err_tied_low", IW'(err_o), IW'(0));
`endif
        drain();

        // Reset in the middle of an item drops the partial item.
        put_word(1'b0, 32'hF0);
        put_word(1'b0, 32'hF1);
        put_word(1'b0, 32'hF2);
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("mid_rst_count", IW'(out_count_o), IW'(0));
        check("mid_rst_valid", IW'(out_valid_o), IW'(0));
        check("mid_rst_ready", IW'(in_ready_o), IW'(1));
        check("mid_rst_err", IW'(err_o), IW'(0));
        out_ready_i = 1'b0;
        ex = '0;
        for (int i = 0; i < 6; i++) ex[i*32 +: 32] = 32'h90 + 32'(i);
        sb_q.push_back({1'b0, ex});
        for (int i = 0; i < 6; i++) put_word(1'b0, 32'h90 + 32'(i));
        idle_in();
        #1;
        check("after_rst_count", IW'(out_count_o), IW'(1));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
